fetch_stage: RTL and testbench

//  Instruction-fetch stage of the WISC pipeline: owns the PC register and the IF/ID pipeline register.

---
 rtl/wisc_pkg.sv | 22 ++
 rtl/pc_adder16.sv | 13 +
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC pipeline.
// Holds the fetch FSM state encoding and the opcode values used by decode and fetch.
package wisc_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StHaltPend = 2'd1,
      StHalted   = 2'd2
   } fetch_state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_BR   = 4'hD;
   localparam logic [3:0] OP_PCS  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/pc_adder16.sv
// Sequential-PC adder.
// Produces a + b truncated to 16 bits; the carry-out is discarded so the PC wraps modulo 2^16.
module pc_adder16
   import wisc_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and HLT tracking FSM.
// Honours load-use stalls, branch redirects from ID and instruction-memory wait cycles.
module fetch_stage
   import wisc_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC    = 16'h0000,
   parameter logic [WORD_W-1:0] PC_INC      = 16'd2,
   parameter logic [3:0]        HALT_OPCODE = OP_HLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              flush,
   input  logic [WORD_W-1:0] branch_target,
   input  logic [WORD_W-1:0] imem_data,
   input  logic              imem_ready,
   input  logic              wb_halt,
   output logic [WORD_W-1:0] imem_addr,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc_plus2,
   output logic              ifid_valid,
   output logic              halted
);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] pc_plus2_q, pc_plus2_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;
   fetch_state_t      state_q, state_d;

   logic [WORD_W-1:0] pc_plus2;
   logic              fetch_ok;
   logic              is_hlt;

   pc_adder16 u_pc_adder (
      .a   (pc_q),
      .b   (PC_INC),
      .sum (pc_plus2)
   );

   assign fetch_ok = imem_ready && (state_q == StRun);
   assign is_hlt   = fetch_ok && (imem_data[15:12] == HALT_OPCODE);

   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus2_d = pc_plus2_q;
      valid_d    = valid_q;
      state_d    = state_q;

      // Once halted everything is frozen; redirects can no longer wake the pipe.
      if (state_q == StHalted) begin
         valid_d = 1'b0;
      end else begin
         if (flush) begin
            pc_d = branch_target;
         end else if (pc_write && imem_ready && (state_q == StRun)) begin
            pc_d = pc_plus2;
         end

         if (flush) begin
            instr_d    = '0;
            pc_plus2_d = '0;
            valid_d    = 1'b0;
         end else if (ifid_write) begin
            if (fetch_ok) begin
               instr_d    = imem_data;
               pc_plus2_d = pc_plus2;
               valid_d    = 1'b1;
            end else begin
               instr_d = '0;
               valid_d = 1'b0;
            end
         end
      end

      unique case (state_q)
         StRun: begin
            // Only a HLT that actually enters IF/ID arms the halt.
            if (is_hlt && pc_write && ifid_write && !flush) state_d = StHaltPend;
         end
         StHaltPend: begin
            // An older HLT reaching WB beats a younger branch squash.
            if (wb_halt)    state_d = StHalted;
            else if (flush) state_d = StRun;
         end
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase

      halted_d = (state_d == StHalted);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         state_q    <= StRun;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         state_q    <= state_d;
      end
   end

   assign imem_addr     = pc_q;
   assign ifid_instr    = instr_q;
   assign ifid_pc_plus2 = pc_plus2_q;
   assign ifid_valid    = valid_q;
   assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Instruction memory is a small array indexed by imem_addr; word i defaults to 16'h1000 + i.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write;
   logic        ifid_write;
   logic        flush;
   logic [15:0] branch_target;
   logic [15:0] imem_data;
   logic        imem_ready;
   logic        wb_halt;
   logic [15:0] imem_addr;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   logic [15:0] mem [256];

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[8:1]];

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_write      (pc_write),
      .ifid_write    (ifid_write),
      .flush         (flush),
      .branch_target (branch_target),
      .imem_data     (imem_data),
      .imem_ready    (imem_ready),
      .wb_halt       (wb_halt),
      .imem_addr     (imem_addr),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      flush         = 1'b0;
      branch_target = 16'h0000;
      imem_ready    = 1'b1;
      wb_halt       = 1'b0;
   endtask

   // Asynchronous pulse placed between clock edges.
   task automatic do_reset();
      set_defaults();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic flush_to(input logic [15:0] target);
      flush         = 1'b1;
      branch_target = target;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      set_defaults();
      rst_n = 1'b0;
      #2;
      checks++; if (imem_addr !== 16'h0000) begin failures++;
         $display("FAIL reset_pc got=%h want=%h", imem_addr, 16'h0000); end
      checks++; if (ifid_instr !== 16'h0000) begin failures++;
         $display("FAIL reset_instr got=%h want=%h", ifid_instr, 16'h0000); end
      checks++; if (ifid_pc_plus2 !== 16'h0000) begin failures++;
         $display("FAIL reset_pc_plus2 got=%h want=%h", ifid_pc_plus2, 16'h0000); end
      checks++; if (ifid_valid !== 1'b0) begin failures++;
         $display("FAIL reset_valid got=%b want=0", ifid_valid); end
      checks++; if (halted !== 1'b0) begin failures++;
         $display("FAIL reset_halted got=%b want=0", halted); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_free_run();
      do_reset();
      tick();
      checks++; if (ifid_instr !== 16'h1234 || ifid_pc_plus2 !== 16'h0002 || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL free_run_1 got=%h/%h/%b want=1234/0002/1",
            ifid_instr, ifid_pc_plus2, ifid_valid); end
      checks++; if (imem_addr !== 16'h0002) begin failures++;
         $display("FAIL free_run_pc1 got=%h want=0002", imem_addr); end
      tick();
      checks++; if (ifid_instr !== 16'h5678 || ifid_pc_plus2 !== 16'h0004 || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL free_run_2 got=%h/%h/%b want=5678/0004/1",
            ifid_instr, ifid_pc_plus2, ifid_valid); end
   endtask

   task automatic test_stall();
      do_reset();
      tick(); tick(); tick();
      checks++; if (imem_addr !== 16'h0006 || ifid_instr !== 16'h1002) begin failures++;
         $display("FAIL stall_setup got=%h/%h want=0006/1002", imem_addr, ifid_instr); end
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      tick();
      checks++; if (imem_addr !== 16'h0006) begin failures++;
         $display("FAIL stall_pc_hold got=%h want=0006", imem_addr); end
      checks++; if (ifid_instr !== 16'h1002 || ifid_pc_plus2 !== 16'h0006 || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL stall_ifid_hold got=%h/%h/%b want=1002/0006/1",
            ifid_instr, ifid_pc_plus2, ifid_valid); end
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      tick();
      checks++; if (ifid_instr !== 16'h1003 || ifid_pc_plus2 !== 16'h0008 || imem_addr !== 16'h0008)
         begin failures++; $display("FAIL stall_resume got=%h/%h/%h want=1003/0008/0008",
            ifid_instr, ifid_pc_plus2, imem_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      tick(); tick(); tick(); tick();
      ifid_write = 1'b0;
      flush_to(16'h0040);
      ifid_write = 1'b1;
      checks++; if (imem_addr !== 16'h0040) begin failures++;
         $display("FAIL flush_pc got=%h want=0040", imem_addr); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc_plus2 !== 16'h0000)
         begin failures++; $display("FAIL flush_squash got=%h/%h/%b want=0000/0000/0",
            ifid_instr, ifid_pc_plus2, ifid_valid); end
      tick();
      checks++; if (ifid_instr !== 16'h1020 || ifid_pc_plus2 !== 16'h0042 || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL flush_target_fetch got=%h/%h/%b want=1020/0042/1",
            ifid_instr, ifid_pc_plus2, ifid_valid); end
   endtask

   task automatic test_halt();
      do_reset();
      flush_to(16'h0010);
      tick();
      checks++; if (ifid_instr !== 16'hF000 || ifid_valid !== 1'b1 || imem_addr !== 16'h0012)
         begin failures++; $display("FAIL halt_capture got=%h/%b/%h want=F000/1/0012",
            ifid_instr, ifid_valid, imem_addr); end
      tick();
      checks++; if (imem_addr !== 16'h0012 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000)
         begin failures++; $display("FAIL halt_pend_bubble got=%h/%b/%h want=0012/0/0000",
            imem_addr, ifid_valid, ifid_instr); end
      tick();
      checks++; if (imem_addr !== 16'h0012 || halted !== 1'b0) begin failures++;
         $display("FAIL halt_pend_hold got=%h/%b want=0012/0", imem_addr, halted); end
      wb_halt = 1'b1;
      tick();
      wb_halt = 1'b0;
      checks++; if (halted !== 1'b1) begin failures++;
         $display("FAIL halt_asserted got=%b want=1", halted); end
      flush_to(16'h0080);
      checks++; if (imem_addr !== 16'h0012 || halted !== 1'b1 || ifid_valid !== 1'b0)
         begin failures++; $display("FAIL halted_frozen got=%h/%b/%b want=0012/1/0",
            imem_addr, halted, ifid_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_addr !== 16'h0000 || halted !== 1'b0) begin failures++;
         $display("FAIL halt_reset got=%h/%b want=0000/0", imem_addr, halted); end
      rst_n = 1'b1;
   endtask

   task automatic test_halt_flush();
      do_reset();
      flush_to(16'h0010);
      tick();
      flush_to(16'h0100);
      checks++; if (imem_addr !== 16'h0100 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL halt_flush_redirect got=%h/%b want=0100/0", imem_addr, ifid_valid); end
      tick();
      checks++; if (imem_addr !== 16'h0102 || ifid_instr !== 16'h1080 || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL halt_flush_run got=%h/%h/%b want=0102/1080/1",
            imem_addr, ifid_instr, ifid_valid); end
      checks++; if (halted !== 1'b0) begin failures++;
         $display("FAIL halt_flush_halted got=%b want=0", halted); end
   endtask

   task automatic test_hlt_stalled();
      do_reset();
      flush_to(16'h0010);
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      tick();
      checks++; if (imem_addr !== 16'h0010 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL hlt_stalled_hold got=%h/%b want=0010/0", imem_addr, ifid_valid); end
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      tick();
      checks++; if (imem_addr !== 16'h0012 || ifid_instr !== 16'hF000) begin failures++;
         $display("FAIL hlt_stalled_refetch got=%h/%h want=0012/F000", imem_addr, ifid_instr); end
      tick();
      checks++; if (imem_addr !== 16'h0012 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL hlt_stalled_pend got=%h/%b want=0012/0", imem_addr, ifid_valid); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      flush_to(16'h0010);
      flush_to(16'h0030);
      checks++; if (imem_addr !== 16'h0030 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL flush_vs_hlt got=%h/%b want=0030/0", imem_addr, ifid_valid); end
      tick();
      checks++; if (imem_addr !== 16'h0032 || ifid_instr !== 16'h1018) begin failures++;
         $display("FAIL flush_vs_hlt_run got=%h/%h want=0032/1018", imem_addr, ifid_instr); end
      flush_to(16'h0010);
      tick();
      wb_halt = 1'b1;
      flush_to(16'h0200);
      wb_halt = 1'b0;
      checks++; if (halted !== 1'b1 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL wbhalt_vs_flush got=%b/%b want=1/0", halted, ifid_valid); end
      tick();
      checks++; if (halted !== 1'b1) begin failures++;
         $display("FAIL wbhalt_vs_flush_stay got=%b want=1", halted); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      flush_to(16'h0020);
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imem_addr !== 16'h0020 || ifid_valid !== 1'b0) begin failures++;
            $display("FAIL mem_stall_%0d got=%h/%b want=0020/0", i, imem_addr, ifid_valid); end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin failures++;
         $display("FAIL mem_stall_reset got=%h/%b want=0000/0", imem_addr, ifid_valid); end
      rst_n      = 1'b1;
      imem_ready = 1'b1;
      tick();
      checks++; if (ifid_instr !== 16'h1234 || ifid_valid !== 1'b1 || imem_addr !== 16'h0002)
         begin failures++; $display("FAIL mem_stall_recover got=%h/%b/%h want=1234/1/0002",
            ifid_instr, ifid_valid, imem_addr); end
   endtask

   task automatic test_wrap();
      do_reset();
      flush_to(16'hFFFE);
      tick();
      checks++; if (imem_addr !== 16'h0000 || ifid_pc_plus2 !== 16'h0000 ||
                    ifid_instr !== 16'h10FF || ifid_valid !== 1'b1)
         begin failures++; $display("FAIL pc_wrap got=%h/%h/%h/%b want=0000/0000/10FF/1",
            imem_addr, ifid_pc_plus2, ifid_instr, ifid_valid); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0] = 16'h1234;
      mem[1] = 16'h5678;
      mem[8] = 16'hF000;
      test_reset();
      test_free_run();
      test_stall();
      test_flush();
      test_halt();
      test_halt_flush();
      test_hlt_stalled();
      test_simultaneous();
      test_mem_stall();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
